// File: rtl/code_packer.sv
// Packs a serial code-bit stream MSB-first into words, buffers them in a small
// circular queue and hands them out on a valid/ready handshake, with padded flush.
module code_packer #(
  parameter int   WORD_W     = 8,
  parameter int   DEPTH_LOG2 = 2,
  parameter logic PAD_BIT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_input,
  input  logic                  input_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WORD_W-1:0]     word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  flush_done,
  output logic [DEPTH_LOG2:0]   buf_level,
  output logic [15:0]           word_count
);

  localparam int CW    = $clog2(WORD_W);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {RUN, PAD, DONE} state_t;

  state_t                state;
  logic [WORD_W-1:0]     acc;
  logic [CW-1:0]         acc_cnt;
  logic [CW-1:0]         acc_cnt_next;
  logic [WORD_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  buf_full;
  logic                  last_bit;
  logic                  accept;
  logic                  pad_push;
  logic                  push;
  logic                  pop;
  logic [CW:0]           shamt;
  logic [WORD_W-1:0]     pad_word;
  logic [WORD_W-1:0]     push_word;

  assign buf_full     = (buf_level == (DEPTH_LOG2+1)'(DEPTH));
  assign last_bit     = (acc_cnt == CW'(WORD_W-1));
  assign in_ready     = (state == RUN) && !(last_bit && buf_full);
  assign accept       = input_valid && in_ready;
  assign word_valid   = (buf_level != '0);
  assign pop          = word_valid && word_ready;
  assign pad_push     = (state == PAD) && !buf_full;
  assign push         = (accept && last_bit) || pad_push;
  assign acc_cnt_next = accept ? (last_bit ? '0 : acc_cnt + CW'(1)) : acc_cnt;
  assign flush_done   = (state == DONE);
  assign word_out     = word_valid ? mem[rd_ptr] : '0;

  // The accumulator fills from the LSB, so a partial word is left-aligned by
  // shifting out the unused positions and filling them with PAD_BIT.
  assign shamt     = (CW+1)'(WORD_W) - {1'b0, acc_cnt};
  assign pad_word  = (acc << shamt) | (PAD_BIT ? ~({WORD_W{1'b1}} << shamt) : '0);
  assign push_word = pad_push ? pad_word : {acc[WORD_W-2:0], bit_input};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      acc        <= '0;
      acc_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      buf_level  <= '0;
      word_count <= '0;
    end else begin
      if (accept) begin
        acc     <= {acc[WORD_W-2:0], bit_input};
        acc_cnt <= acc_cnt_next;
      end
      case (state)
        RUN: begin
          if (flush) begin
            state <= (acc_cnt_next != '0) ? PAD : DONE;
          end
        end
        PAD: begin
          if (!buf_full) begin
            acc_cnt <= '0;
            state   <= DONE;
          end
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + DEPTH_LOG2'(1);
        word_count <= word_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   buf_level <= buf_level + (DEPTH_LOG2+1)'(1);
        2'b01:   buf_level <= buf_level - (DEPTH_LOG2+1)'(1);
        default: buf_level <= buf_level;
      endcase
    end
  end

endmodule

// File: doc/code_packer.md
Name: code_packer

Overview:
- Sits directly downstream of the context-coder queue and consumes its serial code-bit stream (bit_output / output_valid).
- Packs the bits MSB-first into WORD_W-bit words and holds them in a small output buffer.
- Presents the words to the stream writer on a valid/ready handshake.
- An end-of-stream flush pads the partial word with PAD_BIT, emits it, and then signals completion.

Parameters:
- WORD_W, 8, width of packed output word (>=2).
- DEPTH_LOG2, 2, log2 of output buffer depth (4 words default).
- PAD_BIT, 1'b0, fill value for unused low bits of the final word on flush.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- bit_input  in  1  code bit from coder
- input_valid  in  1  bit_input valid this cycle
- in_ready  out  1  packer accepts bit this cycle
- flush  in  1  single-cycle end-of-stream request
- word_out  out  WORD_W  packed word, first-received bit at MSB
- word_valid  out  1  word_out valid
- word_ready  in  1  consumer takes word_out
- flush_done  out  1  one-cycle pulse: flush complete
- buf_level  out  DEPTH_LOG2+1  words currently buffered
- word_count  out  16  words delivered since reset, wraps 0xFFFF->0

Behaviour:
- Reset (async, rst=1):
  - accumulator, acc_cnt, pointers, buf_level, word_count cleared; state RUN.
  - word_valid=0, flush_done=0, word_out=0, in_ready=1 once rst deasserts.
  - Reset mid-word or mid-flush discards partial bits and buffered words.
- Accept: a bit is taken on a rising edge with input_valid && in_ready. It is shifted into the accumulator; acc_cnt increments.
- Word completion: on acceptance of the WORD_W-th bit, the full word is written into the buffer on the same edge and acc_cnt returns to 0.
  - word_valid is visible the cycle after (1-cycle latency from last bit to word_valid when the buffer was empty).
- in_ready = (state==RUN) && !(acc_cnt==WORD_W-1 && buf_full).
  - Partial bits keep accumulating while the buffer is full. Only the word-completing bit stalls.
  - No same-cycle pop credit: full is evaluated on registered state.
- Output buffer:
  - Circular, 2^DEPTH_LOG2 entries.
  - word_out = entry at read pointer; word_valid = buf_level!=0.
  - Pop on word_valid && word_ready; word_count increments on each pop.
  - Simultaneous push and pop leaves buf_level unchanged. Pointers wrap modulo depth.
  - word_out must hold stable while word_valid && !word_ready.
- FSM:
  - RUN: normal accept. flush=1 is latched.
    - If a bit is accepted the same cycle, it is included before padding.
    - Next state PAD if resulting acc_cnt!=0, else DONE.
  - PAD: in_ready=0. When !buf_full, push {acc bits, PAD_BIT fill} (left-aligned), clear acc_cnt, go DONE. Otherwise wait in PAD.
  - DONE: flush_done=1 for exactly this cycle, in_ready=0, then RUN.
  - flush asserted outside RUN is ignored.
- Flush does not wait for the buffer to drain. The consumer drains remaining words afterwards.
- Arithmetic:
  - acc_cnt width clog2(WORD_W).
  - buf_level counts 0..2^DEPTH_LOG2 inclusive.
  - word_count is a 16-bit unsigned wrap counter.

Test Plan:
- Reset: assert rst mid-stream with 3 words buffered -> word_valid=0, buf_level=0, word_count=0 immediately; after release in_ready=1.
- Stream 1,0,1,1,0,0,1,0 back-to-back, word_ready=1 -> word_out=8'hB2, word_valid high the cycle after the 8th bit for one cycle, word_count=1.
- Backpressure: word_ready=0, stream 40 bits -> buf_level reaches 4 after bit 32. in_ready drops after bit 39 (acc_cnt=7) and bit 40 stalls. Raising word_ready emits the 4 words in order, then bit 40 is accepted and the 5th word appears; word_count=5.
- Flush partial: bits 1,1,1 then flush pulse -> one word 8'hE0 (PAD_BIT=0). flush_done pulses exactly once, 2 cycles after flush. in_ready=0 during PAD/DONE.
- Flush empty accumulator -> no word pushed, buf_level unchanged, flush_done pulses the cycle after flush.
- Flush coinciding with an accepted bit that completes a word (8th bit) -> word pushed normally, no padded word, flush_done next cycle. With a full buffer and partial acc, flush stays in PAD until one word pops.
